// File: rtl/maxnet_ctrl_pkg.sv
// MaxNet controller shared types.
// State encoding and datapath float constants.
package maxnet_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    START,
    WAIT,
    CHECK,
    UPDATE,
    FIN
  } state_e;

  localparam logic [31:0] ONE = 32'h3F80_0000;
  localparam int CNT_W = 16;
  localparam int ITER_W = 8;

endpackage

// File: rtl/maxnet_ctrl_if.sv
// MaxNet controller handshake bundle.
// master = controller, slave = datapath/requester.
interface maxnet_ctrl_if;

  logic       go;
  logic       plu_done;
  logic       finish;
  logic       rst_plu;
  logic       eps_reg_we;
  logic       we_prim;
  logic       we_a_reg;
  logic       mux_sel;
  logic       start;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] iter_cnt;

  modport master (
    input  go, plu_done, finish,
    output rst_plu, eps_reg_we, we_prim,
    output we_a_reg, mux_sel, start,
    output busy, done, timeout, iter_cnt
  );

  modport slave (
    output go, plu_done, finish,
    input  rst_plu, eps_reg_we, we_prim,
    input  we_a_reg, mux_sel, start,
    input  busy, done, timeout, iter_cnt
  );

endinterface

// File: rtl/maxnet_wdog.sv
// Loadable up-counter with terminal-count flag.
// Shared by the PLU watchdog and the check-latency wait.
module maxnet_wdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= ld_val;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/maxnet_ctrl.sv
// MaxNet sequencing FSM: load, run PLUs,
// feed results back until finish or a watchdog.
module maxnet_ctrl
  import maxnet_ctrl_pkg::*;
#(
  parameter int MAX_ITER = 64,
  parameter int PLU_TMO  = 1024,
  parameter int CHK_LAT  = 1
) (
  input logic          clk,
  input logic          rst,
  maxnet_ctrl_if.master bus
);

  localparam logic [ITER_W-1:0] IT_MAX =
    ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] IT_LAST =
    ITER_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(PLU_TMO - 1);
  localparam logic [CNT_W-1:0] CHK_LAST =
    CNT_W'(CHK_LAT - 1);

  state_e              state, nxt;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                to_q, to_d;
  logic                wd_load, wd_inc, wd_tc;
  logic [CNT_W-1:0]    wd_tc_val;

  maxnet_wdog #(.W(CNT_W)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .ld_val ('0),
    .inc    (wd_inc),
    .tc_val (wd_tc_val),
    .tc     (wd_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      iter_q <= '0;
      to_q   <= 1'b0;
    end else begin
      state  <= nxt;
      iter_q <= iter_d;
      to_q   <= to_d;
    end
  end

  always_comb begin
    nxt       = state;
    iter_d    = iter_q;
    to_d      = to_q;
    wd_load   = 1'b0;
    wd_inc    = 1'b0;
    wd_tc_val = TMO_LAST;
    unique case (state)
      IDLE: begin
        if (bus.go) begin
          nxt    = LOAD;
          iter_d = '0;
          to_d   = 1'b0;
        end
      end
      LOAD: nxt = CLR;
      CLR:  nxt = START;
      START: begin
        nxt     = WAIT;
        wd_load = 1'b1;
      end
      WAIT: begin
        wd_inc = 1'b1;
        if (bus.plu_done) begin
          nxt     = CHECK;
          wd_load = 1'b1;
        end else if (wd_tc) begin
          nxt  = FIN;
          to_d = 1'b1;
        end
      end
      CHECK: begin
        // same counter re-used as the latency wait
        wd_tc_val = CHK_LAST;
        wd_inc    = 1'b1;
        if (wd_tc) begin
          if (bus.finish) begin
            nxt  = FIN;
            to_d = 1'b0;
          end else if (iter_q == IT_LAST) begin
            nxt    = FIN;
            to_d   = 1'b1;
            iter_d = IT_MAX;
          end else begin
            nxt = UPDATE;
          end
        end
      end
      UPDATE: begin
        nxt = CLR;
        if (iter_q < IT_MAX) begin
          iter_d = iter_q + 1'b1;
        end
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign bus.rst_plu    = (state == IDLE) ||
                          (state == CLR);
  assign bus.eps_reg_we = (state == LOAD);
  assign bus.we_prim    = (state == LOAD);
  assign bus.we_a_reg   = (state == LOAD) ||
                          (state == UPDATE);
  assign bus.mux_sel    = (state == LOAD);
  assign bus.start      = (state == START);
  assign bus.busy       = (state != IDLE) &&
                          (state != FIN);
  assign bus.done       = (state == FIN);
  assign bus.timeout    = to_q;
  assign bus.iter_cnt   = iter_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Randomized bench for maxnet_ctrl against a
// per-cycle expected trace built from the run rules.
module tb_maxnet_ctrl;

  localparam int MAX_ITER = 4;
  localparam int PLU_TMO  = 16;
  localparam int CHK_LAT  = 1;

  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_LOAD = 3'd1;
  localparam logic [2:0] P_CLR  = 3'd2;
  localparam logic [2:0] P_STRT = 3'd3;
  localparam logic [2:0] P_WAIT = 3'd4;
  localparam logic [2:0] P_CHK  = 3'd5;
  localparam logic [2:0] P_UPD  = 3'd6;
  localparam logic [2:0] P_FIN  = 3'd7;

  typedef struct packed {
    logic [2:0] ph;
    logic       go;
    logic       pd;
    logic       fin;
    logic [7:0] it;
    logic       to;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic go = 1'b0;
  logic pd = 1'b0;
  logic fin = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int m_it = 0;
  logic m_to = 1'b0;
  ent_t q[$];

  always #5 clk = ~clk;

  maxnet_ctrl_if bus ();
  assign bus.go       = go;
  assign bus.plu_done = pd;
  assign bus.finish   = fin;

  maxnet_ctrl #(
    .MAX_ITER (MAX_ITER),
    .PLU_TMO  (PLU_TMO),
    .CHK_LAT  (CHK_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {rst_plu,eps,prim,we_a,mux,start,busy,done}
  function automatic logic [7:0] ctl(input logic [2:0] ph);
    case (ph)
      P_IDLE:  return 8'b1000_0000;
      P_LOAD:  return 8'b0111_1010;
      P_CLR:   return 8'b1000_0010;
      P_STRT:  return 8'b0000_0110;
      P_WAIT:  return 8'b0000_0010;
      P_CHK:   return 8'b0000_0010;
      P_UPD:   return 8'b0001_0010;
      default: return 8'b0000_0001;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [2:0] ph,
                               input logic g,
                               input logic p,
                               input logic f,
                               input int it,
                               input logic to);
    q.push_back(ent_t'({ph, g, p, f, 8'(it), to}));
  endfunction

  task automatic chk(input string name, input int got,
                     input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // fin_at: pass whose check sees finish=1 (99 never)
  // stuck_at: pass whose plu_done never rises
  // dfix: fixed PLU delay in WAIT cycles (0 random)
  task automatic build(input int fin_at, input int stuck_at,
                       input int dfix, input logic go_fin);
    int it;
    int d;
    logic to;
    bit ended;
    q.delete();
    push(P_IDLE, 1'b1, rb(), rb(), m_it, m_to);
    it = 0;
    to = 1'b0;
    push(P_LOAD, rb(), rb(), rb(), it, to);
    ended = 0;
    for (int p = 0; !ended; p++) begin
      push(P_CLR, rb(), rb(), rb(), it, to);
      push(P_STRT, rb(), rb(), rb(), it, to);
      if (p == stuck_at) d = 0;
      else if (dfix != 0) d = dfix;
      else d = int'($urandom_range(1, PLU_TMO));
      if (d == 0) begin
        for (int k = 0; k < PLU_TMO; k++)
          push(P_WAIT, rb(), 1'b0, rb(), it, to);
        to = 1'b1;
        ended = 1;
      end else begin
        for (int k = 1; k <= d; k++)
          push(P_WAIT, rb(), k == d, rb(), it, to);
        for (int c = 1; c <= CHK_LAT; c++)
          push(P_CHK, rb(), rb(),
               (c == CHK_LAT) ? (p == fin_at) : rb(),
               it, to);
        if (p == fin_at) begin
          ended = 1;
        end else if (it == MAX_ITER - 1) begin
          it = MAX_ITER;
          to = 1'b1;
          ended = 1;
        end else begin
          push(P_UPD, rb(), rb(), rb(), it, to);
          it++;
        end
      end
    end
    push(P_FIN, go_fin, rb(), rb(), it, to);
    m_it = it;
    m_to = to;
    repeat (2) push(P_IDLE, 1'b0, rb(), rb(), it, to);
  endtask

  int n_st, n_upd, n_eps, n_prim, done_at;
  int it_fin;
  int to_fin;

  task automatic play(input int stop);
    logic [16:0] got;
    logic [16:0] want;
    n_st = 0; n_upd = 0; n_eps = 0; n_prim = 0;
    done_at = -1; it_fin = -1; to_fin = -1;
    for (int i = 0; i < q.size() && i <= stop; i++) begin
      @(posedge clk);
      #1;
      go  = q[i].go;
      pd  = q[i].pd;
      fin = q[i].fin;
      @(negedge clk);
      got = {bus.rst_plu, bus.eps_reg_we, bus.we_prim,
             bus.we_a_reg, bus.mux_sel, bus.start,
             bus.busy, bus.done, bus.timeout,
             bus.iter_cnt};
      want = {ctl(q[i].ph), q[i].to, q[i].it};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL cyc%0d ph=%0d got=%b want=%b",
                 i, q[i].ph, got, want);
      end
      if (bus.start) n_st++;
      if (bus.we_a_reg && !bus.mux_sel) n_upd++;
      if (bus.eps_reg_we) n_eps++;
      if (bus.we_prim) n_prim++;
      if (bus.done) begin
        done_at = i;
        it_fin  = int'(bus.iter_cnt);
        to_fin  = int'(bus.timeout);
      end
    end
  endtask

  initial begin
    #12;
    chk("reset_rst_plu", int'(bus.rst_plu), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_start", int'(bus.start), 0);
    chk("reset_iter", int'(bus.iter_cnt), 0);
    chk("reset_timeout", int'(bus.timeout), 0);
    @(negedge clk);
    rst = 1'b1;

    build(0, 99, 5, 1'b0);
    play(1 << 20);
    chk("t1_done_at", done_at, 10);
    chk("t1_iter", it_fin, 0);
    chk("t1_timeout", to_fin, 0);
    chk("t1_starts", n_st, 1);

    build(2, 99, 0, 1'b1);
    play(1 << 20);
    chk("t2_updates", n_upd, 2);
    chk("t2_eps", n_eps, 1);
    chk("t2_prim", n_prim, 1);
    chk("t2_iter", it_fin, 2);

    build(99, 99, 0, 1'b1);
    play(1 << 20);
    chk("t3_timeout", to_fin, 1);
    chk("t3_iter", it_fin, 4);
    chk("t3_updates", n_upd, 3);
    chk("t3_starts", n_st, 4);

    build(99, 0, 0, 1'b0);
    play(1 << 20);
    chk("t4_done_at", done_at, 20);
    chk("t4_timeout", to_fin, 1);
    chk("t4_iter", it_fin, 0);

    build(1, 99, 0, 1'b0);
    play(1 << 20);
    chk("t5_timeout_clr", to_fin, 0);
    chk("t5_iter", it_fin, 1);

    build(0, 99, PLU_TMO, 1'b0);
    play(1 << 20);
    chk("tmo_edge_done_at", done_at, 21);
    chk("tmo_edge_timeout", to_fin, 0);

    repeat (24) begin
      build(int'($urandom_range(0, 5)),
            int'($urandom_range(0, 9)), 0, rb());
      play(1 << 20);
    end

    build(99, 0, 0, 1'b0);
    play(8);
    #2;
    rst = 1'b0;
    go = 1'b0; pd = 1'b0; fin = 1'b0;
    #1;
    chk("arst_rst_plu", int'(bus.rst_plu), 1);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_we_a", int'(bus.we_a_reg), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_it = 0;
    m_to = 1'b0;
    q.delete();
    repeat (4) push(P_IDLE, 1'b0, rb(), rb(), 0, 1'b0);
    play(1 << 20);
    build(1, 99, 0, 1'b0);
    play(1 << 20);
    chk("post_rst_iter", it_fin, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
